// File: rtl/imem_fetch_pipe.sv
// rtl/imem_fetch_pipe.sv - pipelined synchronous instruction memory with fault checks; optional load port under IMEM_LOAD_EN
module imem_fetch_pipe #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 128,
  parameter int                READ_LAT  = 1,
  parameter string             INIT_FILE = "",
  parameter logic [DATA_W-1:0] ERR_DATA  = '0
) (
  input  logic              Clk,
  input  logic              Reset,
`ifdef IMEM_LOAD_EN
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [DATA_W-1:0] LoadData,
`endif
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] Address,
  output logic              RespValid,
  input  logic              RespReady,
  output logic [DATA_W-1:0] Instruction,
  output logic              RespErr,
  output logic [7:0]        ErrCount
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH * 4);

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  // Power-up contents: word i holds its own byte address
  function automatic mem_t init_mem();
    mem_t packed_words;
    for (int i = 0; i < DEPTH; i++) packed_words[i] = DATA_W'(i * 4);
    return packed_words;
  endfunction

  mem_t mem = init_mem();

  logic              resp_valid;
  logic              advance;
  logic              accept;
  logic              req_fault;
  logic [IDX_W-1:0]  req_idx;
  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;
  logic [7:0]        err_count;

  // Global stall: the whole pipe moves only when the output slot is empty or being taken
  assign advance = !resp_valid || RespReady;

`ifdef IMEM_LOAD_EN
  assign ReqReady = advance && !LoadEn;
`else
  assign ReqReady = advance;
`endif

  assign accept    = ReqValid && ReqReady;
  assign req_idx   = Address[IDX_W+1:2];
  assign req_fault = (Address[1:0] != 2'b00) || (Address >= LIMIT);

  // Stage 1: memory read (or fault substitution) at the accept edge; bubbles enter when nothing is accepted
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_err  <= req_fault;
        s1_data <= req_fault ? ERR_DATA : mem[req_idx];
      end
    end
  end

  // Count accepted faulting fetches, sticking at the top value
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_count <= 8'd0;
    end else if (accept && req_fault && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  assign ErrCount = err_count;

`ifdef IMEM_LOAD_EN
  logic load_fault;
  assign load_fault = (LoadAddr[1:0] != 2'b00) || (LoadAddr >= LIMIT);

  // Load port write; bad load addresses are dropped without touching the error count
  always_ff @(posedge Clk) begin
    if (LoadEn && !load_fault) begin
      mem[LoadAddr[IDX_W+1:2]] <= LoadData;
    end
  end
`endif

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              s2_valid;
      logic              s2_err;
      logic [DATA_W-1:0] s2_data;

      // Stage 2: pure delay register that shifts together with stage 1
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else if (advance) begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          s2_data  <= s1_data;
        end
      end

      assign resp_valid  = s2_valid;
      assign RespErr     = s2_err;
      assign Instruction = s2_data;
    end else begin : g_lat1
      assign resp_valid  = s1_valid;
      assign RespErr     = s1_err;
      assign Instruction = s1_data;
    end
  endgenerate

  assign RespValid = resp_valid;

endmodule

// File: tb/tb_imem_fetch_pipe.sv
// tb/tb_imem_fetch_pipe.sv - bench driving READ_LAT=1 and READ_LAT=2 instances against a queue model
module tb_imem_fetch_pipe;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic        RespReady;
  logic [31:0] Address;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rr1, rv1, re1, rr2, rv2, re2;
  logic [31:0] in1, in2;
  logic [7:0]  ec1, ec2;

  int checks   = 0;
  int failures = 0;

  imem_fetch_pipe #(.READ_LAT(1)) u1 (
    .Clk(Clk), .Reset(Reset),
`ifdef IMEM_LOAD_EN
    .LoadEn(load_en), .LoadAddr(load_addr), .LoadData(load_data),
`endif
    .ReqValid(ReqValid), .ReqReady(rr1), .Address(Address),
    .RespValid(rv1), .RespReady(RespReady), .Instruction(in1),
    .RespErr(re1), .ErrCount(ec1)
  );

  imem_fetch_pipe #(.READ_LAT(2)) u2 (
    .Clk(Clk), .Reset(Reset),
`ifdef IMEM_LOAD_EN
    .LoadEn(load_en), .LoadAddr(load_addr), .LoadData(load_data),
`endif
    .ReqValid(ReqValid), .ReqReady(rr2), .Address(Address),
    .RespValid(rv2), .RespReady(RespReady), .Instruction(in2),
    .RespErr(re2), .ErrCount(ec2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: each instance is a line of READ_LAT slots; front slot is what the consumer sees
  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } ent_t;

  ent_t        q1[$];
  ent_t        q2[$];
  int          c1, c2;
  logic [31:0] ref_mem [128];
  logic        adv1, adv2, acc1, acc2;
  ent_t        n1, n2;

  function automatic logic bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd512);
  endfunction

  function automatic ent_t resp_for(input logic [31:0] a);
    ent_t r;
    r.v = 1'b1;
    r.e = bad(a);
    r.d = r.e ? 32'h0 : ref_mem[a[8:2]];
    return r;
  endfunction

  task automatic model_reset();
    q1.delete();
    q2.delete();
    q1.push_back('0);
    q2.push_back('0);
    q2.push_back('0);
    c1 = 0;
    c2 = 0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'(i * 4);
    model_reset();
  end

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      model_reset();
    end else begin
      adv1 = !q1[0].v || RespReady;
      adv2 = !q2[0].v || RespReady;
      acc1 = adv1 && ReqValid && !load_en;
      acc2 = adv2 && ReqValid && !load_en;
      if (acc1 && bad(Address) && c1 < 255) c1++;
      if (acc2 && bad(Address) && c2 < 255) c2++;
      n1 = '0;
      n2 = '0;
      if (acc1) n1 = resp_for(Address);
      if (acc2) n2 = resp_for(Address);
      if (adv1) begin
        void'(q1.pop_front());
        q1.push_back(n1);
      end
      if (adv2) begin
        void'(q2.pop_front());
        q2.push_back(n2);
      end
      if (load_en && !bad(load_addr)) ref_mem[load_addr[8:2]] = load_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string n, input logic rr, input logic rv, input logic [31:0] ins,
                     input logic re, input logic [7:0] ec, input ent_t m, input int c);
    logic exp_rr;
    exp_rr = (!m.v || RespReady) && !load_en;
    chk({n, " ReqReady"}, 32'(rr), 32'(exp_rr));
    chk({n, " RespValid"}, 32'(rv), 32'(m.v));
    chk({n, " ErrCount"}, 32'(ec), 32'(c));
    if (m.v) begin
      chk({n, " Instruction"}, ins, m.d);
      chk({n, " RespErr"}, 32'(re), 32'(m.e));
    end
  endtask

  // Every cycle, away from the rising edge, both instances must match the model
  always @(negedge Clk) begin
    cmp("u1", rr1, rv1, in1, re1, ec1, q1[0], c1);
    cmp("u2", rr2, rv2, in2, re2, ec2, q2[0], c2);
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0; RespReady = 1'b0; Address = 32'h0;
    load_en = 1'b0; load_addr = 32'h0; load_data = 32'h0;

    mid();
    chk("rst u1 RespValid", 32'(rv1), 32'h0);
    chk("rst u2 RespValid", 32'(rv2), 32'h0);
    chk("rst u1 Instruction", in1, 32'h0);
    chk("rst u2 Instruction", in2, 32'h0);
    chk("rst u1 RespErr", 32'(re1), 32'h0);
    chk("rst u1 ErrCount", 32'(ec1), 32'h0);
    #2 Reset = 1'b0;

    // Back-to-back 0x0, 0x4, 0x1FC
    step(); ReqValid = 1'b1; Address = 32'h0; RespReady = 1'b1;
    step(); Address = 32'h4;
    mid();  chk("lat1 first valid", 32'(rv1), 32'h1); chk("lat1 word0", in1, 32'h0);
            chk("lat2 not yet", 32'(rv2), 32'h0);
    step(); Address = 32'h1FC;
    mid();  chk("lat1 word1", in1, 32'h4); chk("lat2 word0", in2, 32'h0);
    step(); ReqValid = 1'b0;
    mid();  chk("lat1 word2", in1, 32'h1FC); chk("lat1 err", 32'(re1), 32'h0);
            chk("lat2 word1", in2, 32'h4);
    step();
    mid();  chk("lat1 drained", 32'(rv1), 32'h0); chk("lat2 word2", in2, 32'h1FC);
    step();
    mid();  chk("lat2 drained", 32'(rv2), 32'h0);

    // Streaming 0x10, 0x14, 0x18 with two-cycle latency
    step(); ReqValid = 1'b1; Address = 32'h10;
    step(); Address = 32'h14;
    mid();  chk("lat2 edge N", 32'(rv2), 32'h0);
    step(); Address = 32'h18;
    mid();  chk("lat2 edge N+1", 32'(rv2), 32'h1); chk("lat2 0x10", in2, 32'h10);
    step(); ReqValid = 1'b0;
    mid();  chk("lat2 0x14", in2, 32'h14);
    step();
    mid();  chk("lat2 0x18", in2, 32'h18);
    step(); step();

    // Stall with RespReady=0 for three cycles
    step(); ReqValid = 1'b1; Address = 32'h20;
    step(); Address = 32'h24; RespReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("stall ReqReady", 32'(rr1), 32'h0);
      chk("stall hold", in1, 32'h20);
      step();
    end
    RespReady = 1'b1;
    mid();  chk("release ReqReady", 32'(rr1), 32'h1);
    step(); ReqValid = 1'b0;
    mid();  chk("after stall 0x24", in1, 32'h24); chk("after stall valid", 32'(rv1), 32'h1);
    step(); step(); step();

    // Faults: misaligned, first out-of-range word, then a good fetch
    step(); ReqValid = 1'b1; Address = 32'h6;
    step(); Address = 32'h200;
    mid();  chk("misaligned data", in1, 32'h0); chk("misaligned err", 32'(re1), 32'h1);
            chk("count 1", 32'(ec1), 32'd1);
    step(); Address = 32'h8;
    mid();  chk("range data", in1, 32'h0); chk("range err", 32'(re1), 32'h1);
            chk("count 2", 32'(ec1), 32'd2);
    step(); ReqValid = 1'b0;
    mid();  chk("good 0x8", in1, 32'h8); chk("good err", 32'(re1), 32'h0);
    step(); step();

    // 300 faulting fetches saturate the counter
    step(); ReqValid = 1'b1; Address = 32'h201;
    repeat (300) step();
    ReqValid = 1'b0;
    mid();  chk("sat u1", 32'(ec1), 32'd255); chk("sat u2", 32'(ec2), 32'd255);
    step(); step();

    // Asynchronous reset mid-stream, then memory still intact
    ReqValid = 1'b1; Address = 32'h30;
    step(); step();
    #2 Reset = 1'b1;
    #1;
    chk("async u1 RespValid", 32'(rv1), 32'h0);
    chk("async u2 RespValid", 32'(rv2), 32'h0);
    chk("async u1 ErrCount", 32'(ec1), 32'h0);
    chk("async u2 ErrCount", 32'(ec2), 32'h0);
    chk("async u1 Instruction", in1, 32'h0);
    step();
    chk("reset held", 32'(rv1), 32'h0);
    #3 Reset = 1'b0; Address = 32'hC;
    step(); ReqValid = 1'b0;
    mid();  chk("post reset 0xC", in1, 32'hC); chk("post reset valid", 32'(rv1), 32'h1);
    step(); step(); step();

`ifdef IMEM_LOAD_EN
    step(); load_en = 1'b1; load_addr = 32'h8; load_data = 32'h2012001D;
            ReqValid = 1'b1; Address = 32'h8;
    mid();  chk("load blocks req", 32'(rr1), 32'h0);
    step(); load_en = 1'b0;
    mid();  chk("no accept during load", 32'(rv1), 32'h0);
    step(); ReqValid = 1'b0;
    mid();  chk("loaded word", in1, 32'h2012001D);
    step(); step(); step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
